// File: rtl/pwm_pkg.sv
// Shared PWM types and constants: FSM state encoding, default sizing and the
// register-block offsets of the divider and duty registers.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W     = 8;
    localparam int unsigned PWM_DT_CYCLES = 4;

    localparam logic [7:0] PWM_FREQ_DIV_ADDR = 8'h0C;
    localparam logic [7:0] PWM_DUTY_ADDR     = 8'h10;

    typedef enum logic [1:0] {
        PWM_IDLE  = 2'd0,
        PWM_RUN   = 2'd1,
        PWM_DRAIN = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: splits the raw compare level into a true/complement pair
// and holds both low for DT_CYCLES clocks after every raw transition.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DT_CYCLES = PWM_DT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic active_i,
    output logic out_o,
    output logic out_n_o
);

    logic       raw_q;
    logic [7:0] dt_q;
    logic [7:0] dt_d;
    logic       out_q;
    logic       out_n_q;
    logic       edge_det;

    assign edge_det = (raw_i != raw_q);

    // A new raw edge restarts the count, so pulses shorter than the dead-time
    // never reach either output.
    always_comb begin
        dt_d = dt_q;
        if (edge_det) begin
            dt_d = 8'(DT_CYCLES);
        end else if (dt_q != '0) begin
            dt_d = dt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raw_q   <= 1'b0;
            dt_q    <= '0;
            out_q   <= 1'b0;
            out_n_q <= 1'b0;
        end else begin
            raw_q   <= raw_i;
            dt_q    <= dt_d;
            out_q   <= (dt_d == '0) && raw_i;
            out_n_q <= (dt_d == '0) && !raw_i && active_i;
        end
    end

    assign out_o   = out_q;
    assign out_n_o = out_n_q;

endmodule

// File: rtl/pwm_gen.sv
// Single-channel PWM generator with period-boundary double buffering.
// Optional complementary output with dead-time: define PWM_COMP_EN.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W     = PWM_CNT_W,
    parameter int unsigned DT_CYCLES = PWM_DT_CYCLES
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    input  logic             pwm_en,
    input  logic [CNT_W-1:0] pwm_freq_div,
    input  logic [CNT_W-1:0] pwm_duty,
    output logic             pwm_out,
    output logic             pwm_out_n,
    output logic             period_strb,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (DT_CYCLES < 1 || DT_CYCLES > 255) begin : g_dt_range_check
        $error("pwm_gen: DT_CYCLES must be in 1..255");
    end

    pwm_state_t       state_q;
    logic [CNT_W-1:0] div_sh_q;
    logic [CNT_W-1:0] duty_sh_q;
    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             period_strb_q;
    logic             busy_q;

    logic active;
    logic tick;
    logic period_end;
    logic raw;

    assign active     = (state_q != PWM_IDLE);
    assign tick       = active && (presc_q == div_sh_q);
    assign period_end = tick && (cnt_q == CNT_MAX);
    assign raw        = active && (cnt_q < duty_sh_q);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q       <= PWM_IDLE;
            div_sh_q      <= '0;
            duty_sh_q     <= '0;
            presc_q       <= '0;
            cnt_q         <= '0;
            period_strb_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            period_strb_q <= period_end;
            case (state_q)
                PWM_IDLE: begin
                    presc_q <= '0;
                    cnt_q   <= '0;
                    if (pwm_en) begin
                        div_sh_q  <= pwm_freq_div;
                        duty_sh_q <= pwm_duty;
                        state_q   <= PWM_RUN;
                        busy_q    <= 1'b1;
                    end
                end
                PWM_RUN, PWM_DRAIN: begin
                    presc_q <= tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Enable low at a period end retires directly from either
                    // state: the period that was running has just completed.
                    if (period_end) begin
                        if (pwm_en) begin
                            div_sh_q  <= pwm_freq_div;
                            duty_sh_q <= pwm_duty;
                            state_q   <= PWM_RUN;
                            busy_q    <= 1'b1;
                        end else begin
                            state_q <= PWM_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= pwm_en ? PWM_RUN : PWM_DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= PWM_IDLE;
                    presc_q <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign period_strb = period_strb_q;
    assign busy        = busy_q;

`ifdef PWM_COMP_EN
    pwm_deadtime #(
        .DT_CYCLES (DT_CYCLES)
    ) u_deadtime (
        .clk_i    (s_axi_aclk),
        .rst_ni   (s_axi_aresetn),
        .raw_i    (raw),
        .active_i (active),
        .out_o    (pwm_out),
        .out_n_o  (pwm_out_n)
    );
`else
    logic pwm_out_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            pwm_out_q <= 1'b0;
        end else begin
            pwm_out_q <= raw;
        end
    end

    assign pwm_out   = pwm_out_q;
    assign pwm_out_n = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed self-checking bench for pwm_gen (CNT_W=8, DT_CYCLES=4).
module tb_pwm_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_en = 1'b0;
    logic [7:0] pwm_freq_div = '0;
    logic [7:0] pwm_duty = '0;
    logic       pwm_out;
    logic       pwm_out_n;
    logic       period_strb;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int m_first, m_hi, m_nhi, m_both, m_busy, m_strb, m_strb_pos;

    pwm_gen #(
        .CNT_W     (8),
        .DT_CYCLES (4)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .pwm_en        (pwm_en),
        .pwm_freq_div  (pwm_freq_div),
        .pwm_duty      (pwm_duty),
        .pwm_out       (pwm_out),
        .pwm_out_n     (pwm_out_n),
        .period_strb   (period_strb),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Sample n consecutive negedges and accumulate output statistics.
    task automatic measure(input int n);
        m_first = 0; m_hi = 0; m_nhi = 0; m_both = 0;
        m_busy = 0; m_strb = 0; m_strb_pos = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) m_first = int'(pwm_out);
            m_hi   += int'(pwm_out);
            m_nhi  += int'(pwm_out_n);
            m_both += int'(pwm_out && pwm_out_n);
            m_busy += int'(busy);
            if (period_strb) begin
                m_strb++;
                m_strb_pos = i;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pwm_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Enable at a negedge; returns at the negedge just after the RUN-entry edge.
    task automatic start_run(input logic [7:0] div, input logic [7:0] duty);
        pwm_freq_div = div;
        pwm_duty = duty;
        pwm_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pwm_en = 1'b1;
        pwm_duty = 8'd64;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_out: got %b expected 0", pwm_out); end
        checks++; if (pwm_out_n !== 1'b0) begin failures++; $display("FAIL reset_out_n: got %b expected 0", pwm_out_n); end
        checks++; if (period_strb !== 1'b0) begin failures++; $display("FAIL reset_strb: got %b expected 0", period_strb); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        pwm_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        start_run(8'd0, 8'd64);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_entry: got %b expected 1", busy); end
        checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL basic_out_entry: got %b expected 0", pwm_out); end
        measure(256);
        checks++; if (m_first != 1) begin failures++; $display("FAIL basic_first_high: got %0d expected 1", m_first); end
        checks++; if (m_hi != 64) begin failures++; $display("FAIL basic_high1: got %0d expected 64", m_hi); end
        checks++; if (m_strb != 1) begin failures++; $display("FAIL basic_strb_cnt: got %0d expected 1", m_strb); end
        checks++; if (m_strb_pos != 256) begin failures++; $display("FAIL basic_strb_pos: got %0d expected 256", m_strb_pos); end
        checks++; if (m_nhi != 0) begin failures++; $display("FAIL basic_out_n_tied: got %0d expected 0", m_nhi); end
        measure(256);
        checks++; if (m_hi != 64) begin failures++; $display("FAIL basic_high2: got %0d expected 64", m_hi); end
        checks++; if (m_strb_pos != 256) begin failures++; $display("FAIL basic_strb_pos2: got %0d expected 256", m_strb_pos); end
    endtask

    task automatic test_div3();
        do_reset();
        start_run(8'd3, 8'd128);
        measure(1024);
        checks++; if (m_hi != 512) begin failures++; $display("FAIL div3_high: got %0d expected 512", m_hi); end
        checks++; if (m_strb != 1) begin failures++; $display("FAIL div3_strb_cnt: got %0d expected 1", m_strb); end
        checks++; if (m_strb_pos != 1024) begin failures++; $display("FAIL div3_strb_pos: got %0d expected 1024", m_strb_pos); end
    endtask

    task automatic test_duty_change();
        int hi_a;
        do_reset();
        start_run(8'd0, 8'd64);
        measure(100);
        hi_a = m_hi;
        pwm_duty = 8'd200;
        measure(156);
        checks++; if (hi_a + m_hi != 64) begin failures++; $display("FAIL dchg_cur_period: got %0d expected 64", hi_a + m_hi); end
        checks++; if (m_strb_pos != 156) begin failures++; $display("FAIL dchg_strb_pos: got %0d expected 156", m_strb_pos); end
        measure(256);
        checks++; if (m_hi != 200) begin failures++; $display("FAIL dchg_next_period: got %0d expected 200", m_hi); end
    endtask

    task automatic test_boundary();
        do_reset();
        start_run(8'd0, 8'd0);
        measure(256);
        checks++; if (m_hi != 0) begin failures++; $display("FAIL duty0_high: got %0d expected 0", m_hi); end
        checks++; if (m_strb != 1) begin failures++; $display("FAIL duty0_strb: got %0d expected 1", m_strb); end
        do_reset();
        start_run(8'd1, 8'd255);
        measure(512);
        checks++; if (512 - m_hi != 2) begin failures++; $display("FAIL duty255_low: got %0d expected 2", 512 - m_hi); end
        checks++; if (m_strb_pos != 512) begin failures++; $display("FAIL duty255_strb_pos: got %0d expected 512", m_strb_pos); end
    endtask

    task automatic test_drain();
        do_reset();
        start_run(8'd0, 8'd64);
        measure(50);
        pwm_en = 1'b0;
        measure(206);
        checks++; if (m_hi != 14) begin failures++; $display("FAIL drain_high: got %0d expected 14", m_hi); end
        checks++; if (m_busy != 205) begin failures++; $display("FAIL drain_busy_cnt: got %0d expected 205", m_busy); end
        checks++; if (m_strb_pos != 206) begin failures++; $display("FAIL drain_strb_pos: got %0d expected 206", m_strb_pos); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy_end: got %b expected 0", busy); end
        measure(3);
        checks++; if (m_busy + m_hi + m_strb != 0) begin failures++; $display("FAIL drain_idle: got %0d expected 0", m_busy + m_hi + m_strb); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_run(8'd0, 8'd64);
        measure(50);
        pwm_en = 1'b0;
        measure(20);
        checks++; if (m_hi != 14 || m_busy != 20) begin failures++; $display("FAIL b2b_drain: got hi=%0d busy=%0d expected hi=14 busy=20", m_hi, m_busy); end
        pwm_en = 1'b1;
        measure(186);
        checks++; if (m_busy != 186) begin failures++; $display("FAIL b2b_busy_held: got %0d expected 186", m_busy); end
        checks++; if (m_strb_pos != 186) begin failures++; $display("FAIL b2b_strb_pos: got %0d expected 186", m_strb_pos); end
        measure(256);
        checks++; if (m_hi != 64 || m_busy != 256) begin failures++; $display("FAIL b2b_next_period: got hi=%0d busy=%0d expected hi=64 busy=256", m_hi, m_busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_run(8'd0, 8'd64);
        measure(10);
        checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL arst_pre_high: got %b expected 1", pwm_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL arst_out: got %b expected 0", pwm_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b expected 0", busy); end
        pwm_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef PWM_COMP_EN
    task automatic test_comp();
        do_reset();
        start_run(8'd0, 8'd64);
        measure(256);
        checks++; if (m_hi != 60) begin failures++; $display("FAIL comp_high: got %0d expected 60", m_hi); end
        checks++; if (m_nhi != 188) begin failures++; $display("FAIL comp_n_high: got %0d expected 188", m_nhi); end
        checks++; if (m_both != 0) begin failures++; $display("FAIL comp_overlap: got %0d expected 0", m_both); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PWM_COMP_EN
        test_comp();
`else
        test_basic();
        test_div3();
        test_duty_change();
        test_boundary();
        test_drain();
        test_back_to_back();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Single-channel PWM generator fed directly by the AXI-lite register block's PWM frequency-divider and duty registers.
- Drives one servo/motor PWM output for the quadruped leg.
- Double-buffers the divider and duty values so that register writes take effect only at period boundaries. The output therefore never glitches mid-period.
- Runs entirely in the AXI clock domain.

Parameters:
- CNT_W, 8: width of divider, duty and period counter. Period is 2^CNT_W prescaler ticks.
- DT_CYCLES, 4: dead-time in clocks. Used only when PWM_COMP_EN is defined. Legal range 1..255.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- pwm_en  in  1  level enable, from control logic
- pwm_freq_div  in  CNT_W  prescaler divide value. Tick every (div+1) clocks.
- pwm_duty  in  CNT_W  high time in ticks per period
- pwm_out  out  1  PWM output, registered
- pwm_out_n  out  1  complementary output. Constant 0 without PWM_COMP_EN.
- period_strb  out  1  one-clock pulse at each period end
- busy  out  1  high while in RUN or DRAIN

Behaviour:
- Reset (asynchronous assert; release synchronised by the system):
  - pwm_out=0, pwm_out_n=0, period_strb=0, busy=0.
  - State=IDLE; all counters and shadow registers cleared to 0.
  - Reset mid-period forces outputs low immediately.
- States IDLE, RUN, DRAIN:
  - IDLE: outputs low, counters held at 0. If pwm_en=1 on a clock edge, load div_sh<=pwm_freq_div and duty_sh<=pwm_duty, then go to RUN.
  - RUN: if pwm_en=0, go to DRAIN. Otherwise stay.
  - DRAIN: finish the current period, then go to IDLE at the period end. If pwm_en returns to 1 before the period end, go back to RUN with no disturbance to the counters.
- Prescaler:
  - presc counts 0..div_sh in RUN/DRAIN.
  - tick=1 when presc==div_sh, and presc wraps to 0 on that cycle.
  - div_sh=0 gives a tick every clock.
- Period counter:
  - cnt increments on tick and wraps from 2^CNT_W-1 to 0.
  - Period end = tick && cnt==2^CNT_W-1.
- At period end:
  - period_strb=1 for exactly one clock, on the following cycle.
  - Shadows reload from the inputs if pwm_en=1. In DRAIN, the block goes to IDLE instead.
- Compare:
  - raw = (cnt < duty_sh) while in RUN/DRAIN; otherwise 0.
  - pwm_out <= raw, i.e. one register stage.
  - Latency: pwm_en sampled high at edge N gives first pwm_out high after edge N+1 when duty>0.
- Period and duty boundary values:
  - Period in clocks = 2^CNT_W*(div+1).
  - duty=0 keeps the output always low.
  - duty=2^CNT_W-1 gives high time of (2^CNT_W-1)*(div+1) clocks, with 1 tick low per period. 100% duty is not supported.
- Input changes mid-period are ignored until the next period end. Simultaneous input change and period end: the new value is loaded.
- busy=1 in RUN/DRAIN and 0 in IDLE, registered with state.

Optional Feature:
- Macro: PWM_COMP_EN.
- Defined:
  - pwm_out_n is driven as the complement of raw, with dead-time inserted.
  - On each raw edge a dead-time counter loads DT_CYCLES. The newly active output asserts only after the counter reaches 0; both outputs are low during dead-time.
  - Pulses shorter than DT_CYCLES are suppressed on that output.
  - In IDLE and reset, both outputs are low.
- Not defined: pwm_out_n is tied to 0, no dead-time logic is present, and pwm_out timing is as above.

Decomposition:
- Package pwm_pkg:
  - pwm_state_t enum {PWM_IDLE, PWM_RUN, PWM_DRAIN}
  - default CNT_W and DT_CYCLES constants
  - offsets PWM_FREQ_DIV_ADDR=0x0C and PWM_DUTY_ADDR=0x10, shared with the register block
- Sub-module pwm_deadtime: dead-time inserter, instantiated only under PWM_COMP_EN.

Test Plan:
- div=0, duty=64, pwm_en=1 -> pwm_out high 64 clocks / low 192 clocks; period_strb every 256 clocks; first high one clock after RUN entry.
- div=3, duty=128 -> high 512 / low 512 clocks; period 1024.
- Duty changed 64->200 at clock 100 of a div=0 period -> current period stays 64 high; next period is 200 high.
- duty=0 -> pwm_out constant 0 and period_strb still pulses. duty=255, div=1 -> exactly 2 low clocks per 512.
- pwm_en dropped at clock 50 of period -> period completes, busy falls after the final period_strb; pwm_en re-raised in DRAIN -> no gap and busy stays high.
- Async reset at mid-high pulse -> pwm_out=0 with no clock edge. With PWM_COMP_EN, DT_CYCLES=4, duty=64 -> pwm_out high 60 clocks, pwm_out_n high 188 clocks, never both high.
